// File: rtl/regfile_write_arbiter.sv
// Single write port owner for the register file: clears x1..x(NUM_REGS-1) after reset,
// then shares the port between core writeback (priority) and a valid/ready aux writer.
module regfile_write_arbiter #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_data,
    output logic              core_stall,
    input  logic              aux_valid,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_data,
    output logic              aux_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              init_done
);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    localparam logic [ADDR_W-1:0] LastReg = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        MaxWait = 4'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;

    logic core_req;
    logic aux_req;
    logic force_aux;
    logic aux_grant;
    logic core_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            clr_ptr_q  <= ADDR_W'(1);
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        core_req   = core_we && (core_addr != '0);
        aux_req    = aux_valid;
        force_aux  = (wait_cnt_q == MaxWait);
        aux_grant  = 1'b0;
        core_grant = 1'b0;

        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        wait_cnt_d = wait_cnt_q;

        rf_we      = 1'b0;
        rf_addr    = '0;
        rf_data    = '0;
        core_stall = 1'b0;
        aux_ready  = 1'b0;
        init_done  = 1'b0;

        case (state_q)
            StClear: begin
                rf_we      = 1'b1;
                rf_addr    = clr_ptr_q;
                core_stall = 1'b1;
                clr_ptr_d  = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LastReg) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                init_done  = 1'b1;
                aux_grant  = aux_req && (!core_req || force_aux);
                core_grant = core_req && !aux_grant;
                aux_ready  = aux_grant;
                core_stall = core_req && aux_grant;
                if (core_grant) begin
                    rf_we   = 1'b1;
                    rf_addr = core_addr;
                    rf_data = core_data;
                end else if (aux_grant) begin
                    // Aux writes to x0 still complete the handshake but never reach the array.
                    rf_we   = (aux_addr != '0);
                    rf_addr = aux_addr;
                    rf_data = aux_data;
                end
                if (aux_grant || !aux_req) begin
                    wait_cnt_d = '0;
                end else if (!force_aux) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = StClear;
        endcase

        // A reset edge discards whatever would have been granted this cycle.
        if (reset) begin
            rf_we      = 1'b0;
            rf_addr    = '0;
            rf_data    = '0;
            aux_ready  = 1'b0;
            core_stall = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a behavioural model.
module tb_regfile_write_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int MAX_WAIT = 4;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              core_we   = 1'b0;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [DATA_W-1:0] core_data = '0;
    logic              aux_valid = 1'b0;
    logic [ADDR_W-1:0] aux_addr  = '0;
    logic [DATA_W-1:0] aux_data  = '0;
    logic              core_stall;
    logic              aux_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              init_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_data (core_data),
        .core_stall(core_stall),
        .aux_valid (aux_valid),
        .aux_addr  (aux_addr),
        .aux_data  (aux_data),
        .aux_ready (aux_ready),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .init_done (init_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file as written by the DUT's port, and as the model says it should be.
    logic [DATA_W-1:0] tb_rf    [NUM_REGS] = '{default: '0};
    logic [DATA_W-1:0] model_rf [NUM_REGS] = '{default: '0};

    always @(posedge clk) begin
        if (rf_we === 1'b1) tb_rf[rf_addr] <= rf_data;
    end

    // Behavioural model: cycles since reset release, starvation count, grant rules.
    bit armed     = 1'b0;
    bit running   = 1'b0;
    int since_rel = 0;
    int starve    = 0;

    always @(negedge clk) begin
        logic              e_we, e_stall, e_ready, e_done;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        bit                creq, ag, cg;
        int                mism;

        creq = core_we && (core_addr != 0);
        ag   = running && aux_valid && (!creq || starve == MAX_WAIT);
        cg   = running && creq && !ag;
        e_done = running;
        if (!running) begin
            e_we    = 1'b1;
            e_addr  = ADDR_W'(since_rel + 1);
            e_data  = '0;
            e_stall = 1'b1;
            e_ready = 1'b0;
        end else begin
            e_ready = ag;
            e_stall = creq && ag;
            e_we    = cg || (ag && aux_addr != 0);
            e_addr  = cg ? core_addr : (ag ? aux_addr : '0);
            e_data  = cg ? core_data : (ag ? aux_data : '0);
        end
        if (reset) begin
            e_we    = 1'b0;
            e_addr  = '0;
            e_data  = '0;
            e_ready = 1'b0;
            e_stall = 1'b1;
        end

        if (armed) begin
            mism = 0;
            for (int i = 0; i < NUM_REGS; i++) if (tb_rf[i] !== model_rf[i]) mism++;
            chk("m_rf_we", 64'(rf_we), 64'(e_we));
            chk("m_rf_addr", 64'(rf_addr), 64'(e_addr));
            chk("m_rf_data", 64'(rf_data), 64'(e_data));
            chk("m_core_stall", 64'(core_stall), 64'(e_stall));
            chk("m_aux_ready", 64'(aux_ready), 64'(e_ready));
            chk("m_init_done", 64'(init_done), 64'(e_done));
            chk("m_regfile_mismatches", 64'(mism), 64'd0);
        end

        if (reset) begin
            armed     = 1'b1;
            running   = 1'b0;
            since_rel = 0;
            starve    = 0;
        end else begin
            if (e_we) model_rf[e_addr] = e_data;
            if (!running) begin
                since_rel++;
                if (since_rel == NUM_REGS - 1) running = 1'b1;
            end else if (ag || !aux_valid) begin
                starve = 0;
            end else if (starve < MAX_WAIT) begin
                starve++;
            end
        end
    end

    logic stall_s = 1'b1;
    logic ready_s = 1'b0;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Clear sequence after release.
        for (int i = 1; i <= NUM_REGS - 1; i++) begin
            @(negedge clk);
            chk("clr_we", 64'(rf_we), 64'd1);
            chk("clr_addr", 64'(rf_addr), 64'(i));
            chk("clr_data", 64'(rf_data), 64'd0);
            chk("clr_stall", 64'(core_stall), 64'd1);
            chk("clr_done", 64'(init_done), 64'd0);
        end
        @(negedge clk);
        chk("done_cycle32", 64'(init_done), 64'd1);

        // Plain core write.
        @(posedge clk); #1;
        core_we = 1'b1; core_addr = 5'd5; core_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("core_we", 64'(rf_we), 64'd1);
        chk("core_addr", 64'(rf_addr), 64'd5);
        chk("core_data", 64'(rf_data), 64'hDEADBEEF);
        chk("core_nostall", 64'(core_stall), 64'd0);
        @(posedge clk); #1;
        core_we = 1'b0;
        @(negedge clk);
        chk("x5_readback", 64'(tb_rf[5]), 64'hDEADBEEF);

        // Starvation: aux refused 4 times, forced on the 5th (core also targets x7 then).
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            core_we = 1'b1; core_addr = 5'(3 + i); core_data = 32'(i);
            aux_valid = 1'b1; aux_addr = 5'd7; aux_data = 32'h12345678;
            @(negedge clk);
            chk("starve_ready", 64'(aux_ready), 64'(i == 4));
        end
        chk("force_stall", 64'(core_stall), 64'd1);
        chk("force_addr", 64'(rf_addr), 64'd7);
        chk("force_data", 64'(rf_data), 64'h12345678);
        @(posedge clk); #1;
        aux_valid = 1'b0;
        @(negedge clk);
        chk("held_core_addr", 64'(rf_addr), 64'd7);
        chk("held_core_data", 64'(rf_data), 64'd4);
        chk("held_core_nostall", 64'(core_stall), 64'd0);
        @(posedge clk); #1;
        core_we = 1'b0;
        @(negedge clk);
        chk("collision_last_wins", 64'(tb_rf[7]), 64'd4);

        // Core to x0 never blocks aux.
        @(posedge clk); #1;
        core_we = 1'b1; core_addr = 5'd0; core_data = 32'h55;
        aux_valid = 1'b1; aux_addr = 5'd9; aux_data = 32'h99;
        @(negedge clk);
        chk("x0core_ready", 64'(aux_ready), 64'd1);
        chk("x0core_addr", 64'(rf_addr), 64'd9);
        chk("x0core_nostall", 64'(core_stall), 64'd0);

        // Aux to x0: handshake completes, no write.
        @(posedge clk); #1;
        core_we = 1'b0; aux_addr = 5'd0; aux_data = 32'hFFFFFFFF;
        @(negedge clk);
        chk("auxx0_ready", 64'(aux_ready), 64'd1);
        chk("auxx0_we", 64'(rf_we), 64'd0);
        @(posedge clk); #1;
        aux_valid = 1'b0;
        @(negedge clk);
        chk("x0_still_zero", 64'(tb_rf[0]), 64'd0);

        // Reset while aux waits with wait_cnt=2.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            core_we = 1'b1; core_addr = 5'd3; core_data = 32'hA0;
            aux_valid = 1'b1; aux_addr = 5'd12; aux_data = 32'hC;
            @(negedge clk);
            chk("prereset_ready", 64'(aux_ready), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("inreset_ready", 64'(aux_ready), 64'd0);
        chk("inreset_we", 64'(rf_we), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postreset_ready", 64'(aux_ready), 64'd0);
        chk("postreset_done", 64'(init_done), 64'd0);
        chk("postreset_addr", 64'(rf_addr), 64'd1);
        repeat (NUM_REGS - 2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reclear_starve_ready", 64'(aux_ready), 64'(i == 4));
        end
        @(posedge clk); #1;
        core_we = 1'b0; aux_valid = 1'b0;
        @(negedge clk);
        stall_s = core_stall;
        ready_s = aux_ready;

        // Randomized traffic obeying the hold rules, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 299) == 0);
            if (!(core_we && stall_s)) begin
                core_we   = ($urandom_range(0, 2) != 0);
                core_addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
                core_data = $urandom;
            end
            if (!(aux_valid && !ready_s)) begin
                aux_valid = ($urandom_range(0, 1) != 0);
                aux_addr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
                aux_data  = $urandom;
            end
            @(negedge clk);
            stall_s = core_stall;
            ready_s = aux_ready;
        end
        @(posedge clk); #1;
        reset = 1'b0; core_we = 1'b0; aux_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port (we/addr/data) of the 32x32 register file and shares it between two requesters:
  - Core writeback: high priority, no handshake, can be stalled.
  - Auxiliary writer (load-return/debug): valid/ready handshake.
- After reset, sequences a hardware clear of x1..x31 before granting anyone.
- An anti-starvation counter guarantees the aux requester is served within a bounded time.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of registers; the clear walks 1..NUM_REGS-1.
- MAX_WAIT, 4, consecutive refused aux cycles before aux is forced ahead of core (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- core_we  input  1  core writeback request.
- core_addr  input  ADDR_W  core destination register.
- core_data  input  DATA_W  core writeback data.
- core_stall  output  1  core write not accepted this cycle; core must hold its request.
- aux_valid  input  1  aux write request.
- aux_addr  input  ADDR_W  aux destination register.
- aux_data  input  DATA_W  aux write data.
- aux_ready  output  1  aux write accepted this cycle.
- rf_we  output  1  register file write enable.
- rf_addr  output  ADDR_W  register file write address.
- rf_data  output  DATA_W  register file write data.
- init_done  output  1  clear finished, arbiter in RUN.

Behaviour:
- States: CLEAR, RUN. State and counters are registered. Outputs are combinational from registered state plus current inputs.
- Reset (synchronous, takes priority over everything):
  - state<=CLEAR, clr_ptr<=1, wait_cnt<=0.
  - Reset asserted mid-operation aborts any in-progress write grant on that edge and restarts the clear.
- CLEAR state:
  - rf_we=1, rf_addr=clr_ptr, rf_data=0.
  - core_stall=1, aux_ready=0, init_done=0.
  - clr_ptr increments each cycle.
  - When clr_ptr==NUM_REGS-1, next state is RUN.
  - Clear length is exactly NUM_REGS-1 cycles (31 at default).
- RUN state: init_done=1.
  - Definitions:
    - core_req = core_we && core_addr!=0.
    - aux_req = aux_valid.
    - force = (wait_cnt==MAX_WAIT).
  - Grant:
    - aux_grant = aux_req && (!core_req || force).
    - core_grant = core_req && !aux_grant.
  - Outputs:
    - aux_ready = aux_grant.
    - core_stall = core_req && aux_grant.
    - rf_we = core_grant || (aux_grant && aux_addr!=0).
    - rf_addr/rf_data come from the granted requester; both are 0 when no grant.
  - Writes to x0:
    - Core writes to x0 are dropped and never stall.
    - Aux writes to x0 complete the handshake (aux_ready=1) but rf_we=0.
- wait_cnt update:
  - 0 when aux_grant or !aux_valid.
  - Otherwise wait_cnt+1.
  - Never exceeds MAX_WAIT.
- Same-address collision (core and aux to the same register):
  - Resolved purely by the grant rule; only one write per cycle.
  - The losing requester writes in a later cycle, so the last-granted value persists.
- Write latency: a grant in cycle N is visible in the register file from cycle N+1 onward.
- Aux handshake:
  - The aux requester must hold aux_addr/aux_data stable while aux_valid && !aux_ready.
  - The arbiter never drops a pending aux request.

Test Plan:
- Reset held for 2 cycles, then released -> rf_we=1 for exactly 31 cycles with rf_addr stepping 1..31 and rf_data=0. core_stall=1 and init_done=0 throughout. init_done=1 on cycle 32.
- RUN, core_we=1 to x5 with 0xDEADBEEF, aux_valid=0 -> rf_we=1, rf_addr=5, rf_data=0xDEADBEEF, core_stall=0. Register file reads back 0xDEADBEEF next cycle.
- core_we continuously (x3, x4, ...) with aux_valid=1 to x7 with 0x12345678 -> aux_ready=0 for 4 cycles. On the 5th cycle aux_ready=1, core_stall=1, rf_addr=7. The next cycle the core write to the held address proceeds and wait_cnt=0.
- core_we=1 to x0 and aux_valid=1 to x9 in the same cycle -> aux granted immediately (rf_addr=9), core_stall=0.
- aux_valid=1 to x0 with 0xFFFFFFFF, core idle -> aux_ready=1, rf_we=0. x0 still reads 0.
- reset pulsed while aux is waiting (wait_cnt=2) -> aux_ready=0 and init_done=0 on the following cycle. The clear restarts from x1, and wait_cnt=0 after the clear.
